// File: rtl/gen_alg_pkg.sv
// Shared definitions for the limb-serial wide adder sequencer.
package gen_alg_pkg;

  localparam int unsigned LIMB_W_DEF = 16;
  localparam int unsigned LIMBS_DEF  = 4;
  localparam int unsigned WD_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/wide_add_seq_if.sv
// Link between the sequencer (master) and the external registered limb adder (slave).
interface wide_add_seq_if
  import gen_alg_pkg::*;
#(
  parameter int unsigned LIMB_W = LIMB_W_DEF
);

  logic [LIMB_W-1:0] add_a;
  logic [LIMB_W-1:0] add_b;
  logic              add_en;
  logic              add_cin;
  logic [LIMB_W-1:0] add_result;
  logic              add_cout;
  logic              add_vail;

  modport master (
    output add_a, add_b, add_en, add_cin,
    input  add_result, add_cout, add_vail
  );

  modport slave (
    input  add_a, add_b, add_en, add_cin,
    output add_result, add_cout, add_vail
  );

endinterface

// File: rtl/wide_add_seq.sv
// Wide add/subtract built by feeding one limb per round trip through an
// external registered adder, LSB limb first, with a per-limb watchdog.
module wide_add_seq
  import gen_alg_pkg::*;
#(
  parameter int unsigned LIMB_W = LIMB_W_DEF,
  parameter int unsigned LIMBS  = LIMBS_DEF,
  parameter int unsigned WD_MAX = WD_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LIMB_W*LIMBS-1:0]  a,
  input  logic [LIMB_W*LIMBS-1:0]  b,
  input  logic                     sub,
  output logic                     busy,
  output logic                     done,
  output logic [LIMB_W*LIMBS-1:0]  sum,
  output logic                     carry_out,
  output logic                     overflow,
  output logic                     err,
  wide_add_seq_if.master           add
);

  localparam int unsigned IDX_W = (LIMBS  > 1) ? $clog2(LIMBS)  : 1;
  localparam int unsigned WD_W  = (WD_MAX > 1) ? $clog2(WD_MAX) : 1;

  state_e                         state;
  logic [LIMBS-1:0][LIMB_W-1:0]   a_q;
  logic [LIMBS-1:0][LIMB_W-1:0]   b_q;
  logic [LIMBS-1:0][LIMB_W-1:0]   sum_q;
  logic                           carry_q;
  logic [IDX_W-1:0]               idx;
  logic [WD_W-1:0]                wd_cnt;

  logic                           last_limb;
  logic                           wd_expired;
  logic                           sum_top_nxt;
  logic                           ovf_nxt;

  // Result flags are registered on the edge entering DONE, so the top sum
  // bit has to come from the limb being written on that same edge.
  always_comb begin
    last_limb   = (idx == IDX_W'(LIMBS - 1));
    wd_expired  = (wd_cnt == WD_W'(WD_MAX - 1));
    sum_top_nxt = sum_q[LIMBS-1][LIMB_W-1];
    if (add.add_vail && last_limb) begin
      sum_top_nxt = add.add_result[LIMB_W-1];
    end
    ovf_nxt = (a_q[LIMBS-1][LIMB_W-1] == b_q[LIMBS-1][LIMB_W-1]) &&
              (sum_top_nxt != a_q[LIMBS-1][LIMB_W-1]);
  end

  // Sequencer: capture operands, walk limbs through the adder, watch for stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      wd_cnt    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= sub ? ~b : b;
            carry_q   <= sub;
            idx       <= '0;
            sum_q     <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (add.add_vail) begin
            sum_q[idx] <= add.add_result;
            carry_q    <= add.add_cout;
            if (last_limb) begin
              carry_out <= add.add_cout;
              overflow  <= ovf_nxt;
              state     <= ST_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_ISSUE;
            end
          end else if (wd_expired) begin
            err       <= 1'b1;
            carry_out <= carry_q;
            overflow  <= ovf_nxt;
            state     <= ST_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status and adder drive decoded from state; adder operands forced to zero when idle.
  always_comb begin
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
    add.add_en  = (state == ST_ISSUE);
    add.add_a   = '0;
    add.add_b   = '0;
    add.add_cin = 1'b0;
    if (state == ST_ISSUE) begin
      add.add_a   = a_q[idx];
      add.add_b   = b_q[idx];
      add.add_cin = carry_q;
    end
  end

  assign sum = sum_q;

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 Parameter LIMB_W, default 16: width of one limb; equals the downstream adder operand width.
REQ-002 Parameter LIMBS, default 4: limbs per operand; total width N = LIMB_W*LIMBS (64).
REQ-003 Parameter WD_MAX, default 4: cycles to wait for add_vail before flagging an error.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 a  in  N  operand A, captured on accepted start.
REQ-008 b  in  N  operand B, captured on accepted start.
REQ-009 sub  in  1  captured on start; 1 = A-B, 0 = A+B.
REQ-010 busy  out  1  high from the cycle after start acceptance until DONE is left.
REQ-011 done  out  1  one-cycle pulse; sum/carry_out/overflow/err valid while done=1 and held until next start.
REQ-012 sum  out  N  result, modulo 2^N.
REQ-013 carry_out  out  1  carry out of the top limb (sub: 1 = no borrow).
REQ-014 overflow  out  1  two's-complement signed overflow of the N-bit operation.
REQ-015 err  out  1  watchdog expired during this operation.
REQ-016 add_a, add_b  out  LIMB_W  limb operands to the 16-bit registered adder.
REQ-017 add_en, add_cin  out  1  adder enable and carry-in.
REQ-018 add_result  in  LIMB_W; add_cout  in  1; add_vail  in  1  adder outputs, valid one cycle after add_en.

Function
REQ-019 States: IDLE, ISSUE, WAIT, DONE; shared enum.
REQ-020 IDLE: start=1 -> capture a, b (b inverted when sub=1), carry register = sub, limb index = 0, go ISSUE; start=0 -> stay.
REQ-021 ISSUE (one cycle): add_en=1, add_a/add_b = current limb, add_cin = carry register; go WAIT.
REQ-022 WAIT: add_en=0; on add_vail=1 write add_result into sum limb[index], carry register <= add_cout; last limb -> DONE, else index+1 -> ISSUE.
REQ-023 WAIT watchdog: counter cleared on entry; if add_vail not seen within WD_MAX cycles, set err, go DONE with partial sum.
REQ-024 DONE (one cycle): done=1, carry_out = carry register, overflow = (a[N-1]==b'[N-1]) && (sum[N-1]!=a[N-1]), b' = captured (possibly inverted) B; go IDLE.
REQ-025 Latency with a single-cycle adder: start accepted at edge 0 -> done high in cycle 2*LIMBS+1 (9 for defaults).
REQ-026 start while busy or in DONE is ignored, not queued.
REQ-027 add_en is never high outside ISSUE; add_a/add_b/add_cin are 0 when add_en=0.
REQ-028 Limb order LSB first; carry chained exactly once per limb.

Reset
REQ-029 rst=1 at any clock edge (including mid-operation) -> IDLE; busy, done, err, add_en, add_cin, carry_out, overflow = 0; sum, add_a, add_b = 0; captured operands and counters = 0.
REQ-030 rst has priority over start in the same cycle.

Structure
REQ-031 Package gen_alg_pkg holds the state enum, LIMB_W default and WD_MAX default.
REQ-032 No sub-module; the adder is instantiated beside this block at the next level up and connected through the add_* ports.

Verification
REQ-033 a=0x0000_0000_0000_FFFF, b=1, sub=0 -> sum=0x0000_0000_0001_0000, carry_out=0, overflow=0, done in cycle 9.
REQ-034 a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0, carry_out=1, overflow=0.
REQ-035 a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, overflow=1; then a=0, b=1, sub=1 -> sum=all ones, carry_out=0, overflow=0.
REQ-036 Stub add_vail held low from limb 2 -> err=1, done pulse 4 cycles after WAIT entry, limbs 0-1 of sum correct.
REQ-037 Assert rst during third WAIT, release, start a=5, b=3 -> outputs zero during reset, sum=8 with no residue from the aborted operation.
REQ-038 start pulsed every cycle for 20 cycles -> exactly two operations accepted, busy never drops between accepted start and DONE.
